btn_debounce_multi: RTL and testbench

Parametrised multi-channel debouncer for mechanical switches and buttons. All channels share one prescaler tick. Each channel has its own 2-flop synchroniser, stability counter and 4-state FSM. Outputs are registered (Moore): a clean level per channel plus single-cycle press and release strobes, for direct use by downstream control FSMs.

---
 rtl/btn_debounce_multi.sv | 165 ++++++++++++++++
 tb/tb_btn_debounce_multi.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/btn_debounce_multi.sv
// rtl/btn_debounce_multi.sv - multi-channel switch debouncer sharing one sample tick
// Define LONG_PRESS_EN to build the per-channel long-press hold pulse.
module btn_debounce_multi #(
  parameter int CH           = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int LONG_TICKS   = 100
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
`ifdef LONG_PRESS_EN
  ,
  output logic [CH-1:0] hold
`endif
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CMAX = CW'(STABLE_TICKS - 1);

  localparam logic [1:0] ST_ZERO  = 2'd0;
  localparam logic [1:0] ST_WAIT1 = 2'd1;
  localparam logic [1:0] ST_ONE   = 2'd2;
  localparam logic [1:0] ST_WAIT0 = 2'd3;

  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
    end else if (pcnt == PMAX) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign tick = (pcnt == PMAX);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic          s1;
    logic          s2;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          db_q;
    logic          rise_q;
    logic          fall_q;
    logic          go_one;
    logic          go_zero;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1 <= 1'b0;
        s2 <= 1'b0;
      end else begin
        s1 <= sw[i];
        s2 <= s1;
      end
    end

    // The first tick after entering a wait state is partial, so confirmation needs STABLE_TICKS ticks after entry
    assign go_one  = (state == ST_WAIT1) && s2 && tick && (cnt == CMAX);
    assign go_zero = (state == ST_WAIT0) && !s2 && tick && (cnt == CMAX);

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state  <= ST_ZERO;
        cnt    <= '0;
        db_q   <= 1'b0;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
      end else begin
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        case (state)
          ST_ZERO: begin
            if (s2) begin
              state <= ST_WAIT1;
              cnt   <= '0;
            end
          end
          ST_WAIT1: begin
            if (!s2) begin
              state <= ST_ZERO;
            end else if (go_one) begin
              state  <= ST_ONE;
              db_q   <= 1'b1;
              rise_q <= 1'b1;
            end else if (tick) begin
              cnt <= cnt + CW'(1);
            end
          end
          ST_ONE: begin
            if (!s2) begin
              state <= ST_WAIT0;
              cnt   <= '0;
            end
          end
          ST_WAIT0: begin
            if (s2) begin
              state <= ST_ONE;
            end else if (go_zero) begin
              state  <= ST_ZERO;
              db_q   <= 1'b0;
              fall_q <= 1'b1;
            end else if (tick) begin
              cnt <= cnt + CW'(1);
            end
          end
          default: begin
            state <= ST_ZERO;
            cnt   <= '0;
            db_q  <= 1'b0;
          end
        endcase
      end
    end

    assign db[i]   = db_q;
    assign rise[i] = rise_q;
    assign fall[i] = fall_q;

`ifdef LONG_PRESS_EN
    localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam logic [HW-1:0] HMAX = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HPRE = HW'(LONG_TICKS - 1);

    logic [HW-1:0] hcnt;
    logic          hold_q;

    // Saturating at HMAX gives one pulse per press; only a fresh WAIT1->ONE entry clears it
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        hcnt   <= '0;
        hold_q <= 1'b0;
      end else begin
        hold_q <= 1'b0;
        if (go_one) begin
          hcnt <= '0;
        end else if (((state == ST_ONE) || (state == ST_WAIT0)) && tick && (hcnt != HMAX)) begin
          hcnt <= hcnt + HW'(1);
          if (hcnt == HPRE) begin
            hold_q <= 1'b1;
          end
        end
      end
    end

    assign hold[i] = hold_q;
`endif
  end

`ifndef LONG_PRESS_EN
  // LONG_TICKS only sizes the hold counters, which this build leaves out
  if (LONG_TICKS < 0) begin : g_no_long
  end
`endif

endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb/tb_btn_debounce_multi.sv - directed and random checks of btn_debounce_multi against a deadline model
// Define LONG_PRESS_EN to also check the hold pulses.
module tb_btn_debounce_multi;
  localparam int CH = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] sw = '0;
  logic [CH-1:0] db;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          tick;
`ifdef LONG_PRESS_EN
  logic [CH-1:0] hold;
`endif

  int checks = 0;
  int errors = 0;

  // Model: n = edges since reset release; a channel's level flips at a precomputed edge deadline
  int            n;
  logic [CH-1:0] samp1, samp2;
  logic [CH-1:0] db_m, rise_m, fall_m, hold_m;
  int            dl[CH];
  int            hdl[CH];

  int rc[CH], fc[CH], hc[CH], last_rise[CH], last_hold[CH];
  int tick_cnt;

  btn_debounce_multi #(
    .CH(CH), .TICK_DIV(TD), .STABLE_TICKS(ST), .LONG_TICKS(LT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw(sw),
    .db(db),
    .rise(rise),
    .fall(fall),
    .tick(tick)
`ifdef LONG_PRESS_EN
    ,
    .hold(hold)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at edge %0d", tag, obs, exp, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    samp1 = '0;
    samp2 = '0;
    db_m = '0;
    rise_m = '0;
    fall_m = '0;
    hold_m = '0;
    for (int i = 0; i < CH; i++) begin
      dl[i] = -1;
      hdl[i] = -1;
    end
  endtask

  // Ticks land on edges that are multiples of TD; the edge that starts a wait does not count
  task automatic model_edge();
    logic [CH-1:0] s;
    n++;
    s = samp2;
    samp2 = samp1;
    samp1 = sw;
    rise_m = '0;
    fall_m = '0;
    hold_m = '0;
    for (int i = 0; i < CH; i++) begin
      if (db_m[i] && hdl[i] == n) hold_m[i] = 1'b1;
      if (s[i] == db_m[i]) begin
        dl[i] = -1;
      end else if (dl[i] < 0) begin
        dl[i] = (n / TD + 1) * TD + (ST - 1) * TD;
      end else if (n == dl[i]) begin
        db_m[i] = ~db_m[i];
        dl[i] = -1;
        if (db_m[i]) begin
          rise_m[i] = 1'b1;
          hdl[i] = n + LT * TD;
        end else begin
          fall_m[i] = 1'b1;
          hdl[i] = -1;
        end
      end
    end
  endtask

  task automatic step(input logic [CH-1:0] v);
    sw = v;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("db", 32'(db), 32'(db_m));
    chk("rise", 32'(rise), 32'(rise_m));
    chk("fall", 32'(fall), 32'(fall_m));
    chk("tick", 32'(tick), 32'((n + 1) % TD == 0));
`ifdef LONG_PRESS_EN
    chk("hold", 32'(hold), 32'(hold_m));
`endif
    if (tick === 1'b1) tick_cnt++;
    for (int i = 0; i < CH; i++) begin
      if (rise[i] === 1'b1) begin rc[i]++; last_rise[i] = n; end
      if (fall[i] === 1'b1) fc[i]++;
`ifdef LONG_PRESS_EN
      if (hold[i] === 1'b1) begin hc[i]++; last_hold[i] = n; end
`endif
    end
  endtask

  task automatic hold_sw(input logic [CH-1:0] v, input int cycles);
    for (int k = 0; k < cycles; k++) step(v);
  endtask

  task automatic wait_db(input int ch, input logic val, input logic [CH-1:0] v, input int maxc, output int lat);
    lat = 1;
    step(v);
    while (db[ch] !== val && lat < maxc) begin
      step(v);
      lat++;
    end
  endtask

  initial begin
    int lat, r0, f0, h1;
    logic [CH-1:0] rv;
    model_reset();
    for (int i = 0; i < CH; i++) begin
      rc[i] = 0; fc[i] = 0; hc[i] = 0; last_rise[i] = 0; last_hold[i] = 0;
    end
    tick_cnt = 0;
    repeat (3) @(negedge clk);
    chk("reset_db", 32'(db), 0);
    chk("reset_rise", 32'(rise), 0);
    chk("reset_fall", 32'(fall), 0);
    chk("reset_tick", 32'(tick), 0);
    reset = 1'b0;

    // 1: idle
    hold_sw(2'b00, 50);
    chk("idle_ticks", 32'(tick_cnt), 12);
    chk("idle_pulses", 32'(rc[0] + rc[1] + fc[0] + fc[1]), 0);

    // 2: clean press on channel 0 at a random prescaler phase
    hold_sw(2'b00, $urandom_range(0, 3));
    r0 = rc[0];
    wait_db(0, 1'b1, 2'b01, 30, lat);
    chk("press_lat_ok", 32'(lat >= 11 && lat <= 15), 1);
    hold_sw(2'b01, 20);
    chk("press_rise_once", 32'(rc[0] - r0), 1);
    chk("press_ch1_quiet", 32'(rc[1]), 0);

    // 3: bounce then settle
    wait_db(0, 1'b0, 2'b00, 30, lat);
    chk("release_db0", 32'(db[0]), 0);
    hold_sw(2'b00, $urandom_range(1, 6));
    r0 = rc[0];
    for (int c = 0; c < 40; c++) step(((c / 3) % 2 == 0) ? 2'b01 : 2'b00);
    chk("bounce_no_rise", 32'(rc[0] - r0), 0);
    wait_db(0, 1'b1, 2'b01, 30, lat);
    chk("settle_lat_ok", 32'(lat <= 15), 1);
    hold_sw(2'b01, 5);

    // 4: release with a glitch back to 1
    f0 = fc[0];
    hold_sw(2'b00, 4);
    hold_sw(2'b01, 2);
    chk("glitch_no_fall", 32'(fc[0] - f0), 0);
    wait_db(0, 1'b0, 2'b00, 30, lat);
    chk("release_lat_ok", 32'(lat <= 15), 1);
    hold_sw(2'b00, 5);
    chk("release_fall_once", 32'(fc[0] - f0), 1);

    // 5: both pressed, then reset mid-wait
    hold_sw(2'b00, $urandom_range(0, 3));
    hold_sw(2'b11, 8);
    reset = 1'b1;
    #1;
    chk("midreset_db", 32'(db), 0);
    chk("midreset_rise", 32'(rise), 0);
    chk("midreset_fall", 32'(fall), 0);
    chk("midreset_tick", 32'(tick), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    r0 = rc[0];
    h1 = rc[1];
    hold_sw(2'b11, 10);
    chk("postreset_no_rise", 32'(rc[0] - r0 + rc[1] - h1), 0);
    hold_sw(2'b11, 10);
    chk("requal_db", 32'(db), 32'(2'b11));
    chk("requal_rise", 32'(rc[0] - r0 + rc[1] - h1), 2);

`ifdef LONG_PRESS_EN
    // 6: long press on channel 1, twice
    hold_sw(2'b00, 25);
    h1 = hc[1];
    hold_sw(2'b10, 60);
    chk("long_once", 32'(hc[1] - h1), 1);
    chk("long_delay", 32'(last_hold[1] - last_rise[1]), LT * TD);
    hold_sw(2'b00, 25);
    hold_sw(2'b10, 60);
    chk("long_again", 32'(hc[1] - h1), 2);
`endif

    // 7: random runs on both channels
    for (int k = 0; k < 60; k++) begin
      rv = CH'($urandom_range(0, 3));
      hold_sw(rv, $urandom_range(1, 20));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
